uart_tx: RTL and testbench

- UART transmitter, the counterpart of the 16x-oversampling UART receiver; drives the serial line toward a receiver on the same 16x baud clock.
- Frame format: 8N1 by default, LSB first.
- Accepts one byte per start pulse and serialises it as start bit, data bits, optional parity bit, then stop bit(s), each held OVERSAMPLE clocks.
- Sits between the byte-producing logic (test pattern / loopback controller) and the FPGA TX pin.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_bit_timer.sv | 29 ++
 rtl/uart_tx.sv | 157 +++++++++++++++
 tb/tb_uart_tx.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, line levels and parity helper (UART_TX_PARITY_EN adds the parity state)
package uart_pkg;

    localparam int   OVERSAMPLE_DEFAULT = 16;
    localparam logic IDLE_LEVEL         = 1'b1;
    localparam logic START_LEVEL        = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_BIT,
        ST_DATA_BITS,
`ifdef UART_TX_PARITY_EN
        ST_PARITY_BIT,
`endif
        ST_STOP_BIT
    } tx_state_t;

    // Even parity over up to 8 data bits; unused upper bits must be zero.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - oversample counter with clear and terminal-count pulse
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    // Count clocks within a bit; wrap to zero on terminal count, never beyond.
    always_ff @(posedge clk) begin
        if (rst || clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, LSB first, optional even parity under UART_TX_PARITY_EN
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 out,
    output logic                 busy,
    output logic                 done
);

    localparam int            BW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    tx_state_t            state, state_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
    logic                 out_nxt, busy_nxt, done_nxt;
    logic                 tick;
    logic                 timer_clear;

`ifdef UART_TX_PARITY_EN
    logic parity_q;

    // Parity is fixed at accept so later data_in changes cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (en && state == ST_IDLE && start) begin
            parity_q <= even_parity(8'(data_in));
        end
    end
`endif

    // The bit clock restarts from zero on every accept and whenever the block is idle or disabled.
    assign timer_clear = (state == ST_IDLE) || !en;

    uart_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(timer_clear),
        .tick (tick)
    );

    // State and registered line outputs; outputs are registered so the line is glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            out     <= IDLE_LEVEL;
            busy    <= 1'b0;
            done    <= 1'b0;
            shift   <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            out     <= out_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            shift   <= shift_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    // Next state and next line value; bits advance only on the timer's terminal count.
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_cnt_nxt = bit_cnt;
        out_nxt     = out;
        busy_nxt    = busy;
        done_nxt    = 1'b0;

        if (!en) begin
            state_nxt   = ST_IDLE;
            out_nxt     = IDLE_LEVEL;
            busy_nxt    = 1'b0;
            bit_cnt_nxt = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    out_nxt  = IDLE_LEVEL;
                    busy_nxt = 1'b0;
                    if (start) begin
                        shift_nxt   = data_in;
                        bit_cnt_nxt = '0;
                        busy_nxt    = 1'b1;
                        out_nxt     = START_LEVEL;
                        state_nxt   = ST_START_BIT;
                    end
                end
                ST_START_BIT: begin
                    if (tick) begin
                        state_nxt   = ST_DATA_BITS;
                        out_nxt     = shift[0];
                        bit_cnt_nxt = '0;
                    end
                end
                ST_DATA_BITS: begin
                    if (tick) begin
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
                            state_nxt   = ST_PARITY_BIT;
                            out_nxt     = parity_q;
`else
                            state_nxt   = ST_STOP_BIT;
                            out_nxt     = IDLE_LEVEL;
`endif
                        end else begin
                            shift_nxt   = shift >> 1;
                            out_nxt     = shift[1];
                            bit_cnt_nxt = bit_cnt + BW'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY_BIT: begin
                    if (tick) begin
                        state_nxt   = ST_STOP_BIT;
                        out_nxt     = IDLE_LEVEL;
                        bit_cnt_nxt = '0;
                    end
                end
`endif
                ST_STOP_BIT: begin
                    if (tick) begin
                        if (bit_cnt == LAST_STOP) begin
                            state_nxt   = ST_IDLE;
                            out_nxt     = IDLE_LEVEL;
                            busy_nxt    = 1'b0;
                            done_nxt    = 1'b1;
                            bit_cnt_nxt = '0;
                        end else begin
                            bit_cnt_nxt = bit_cnt + BW'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    out_nxt   = IDLE_LEVEL;
                    busy_nxt  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-level line model
module tb_uart_tx;

    localparam int DB = 8;
    localparam int OS = 16;
    localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int L = OS * (1 + DB + PB + SB);

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       start;
    logic [7:0] data_in;
    logic       out;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx #(
        .DATA_BITS (DB),
        .OVERSAMPLE(OS),
        .STOP_BITS (SB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .start  (start),
        .data_in(data_in),
        .out    (out),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Expected line level c cycles after accept (c = 1..L): bit slots of OS cycles each.
    function automatic logic exp_line(input logic [7:0] b, input int c);
        int slot;
        slot = (c - 1) / OS;
        if (slot == 0) return 1'b0;
        if (slot <= DB) return b[slot-1];
        if (PB == 1 && slot == DB + 1) return ^b;
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("idle_out[%0d]", i), 32'(out), 32'd1);
            check($sformatf("idle_busy[%0d]", i), 32'(busy), 32'd0);
            check($sformatf("idle_done[%0d]", i), 32'(done), 32'd0);
            start   = 1'b0;
            data_in = 8'($urandom);
        end
    endtask

    // abort_kind: 1 drops en, 2 pulses rst, during cycle abort_c of the frame.
    task automatic run_frame(input logic [7:0] b, input bit pre_started, input int poke_c,
                             input int abort_c, input int abort_kind,
                             input bit chain, input logic [7:0] nb);
        if (!pre_started) begin
            @(negedge clk);
            start   = 1'b1;
            data_in = b;
        end
        for (int c = 1; c <= L + 1; c++) begin
            @(negedge clk);
            if (abort_c > 0 && c == abort_c + 1) begin
                check($sformatf("abort_out[%02h]", b), 32'(out), 32'd1);
                check($sformatf("abort_busy[%02h]", b), 32'(busy), 32'd0);
                check($sformatf("abort_done[%02h]", b), 32'(done), 32'd0);
                rst   = 1'b0;
                en    = 1'b0;
                start = 1'b0;
                check_idle(4);
                en = 1'b1;
                check_idle(L);
                return;
            end
            check($sformatf("out[%02h c%0d]", b, c), 32'(out),
                  (c <= L) ? 32'(exp_line(b, c)) : 32'd1);
            check($sformatf("busy[%02h c%0d]", b, c), 32'(busy), (c <= L) ? 32'd1 : 32'd0);
            check($sformatf("done[%02h c%0d]", b, c), 32'(done), (c == L + 1) ? 32'd1 : 32'd0);
            start   = 1'b0;
            data_in = 8'($urandom);
            if (c == poke_c) begin
                start   = 1'b1;
                data_in = 8'h3C;
            end
            if (c == abort_c) begin
                if (abort_kind == 1) en = 1'b0;
                else rst = 1'b1;
            end
            if (chain && c == L + 1) begin
                start   = 1'b1;
                data_in = nb;
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b1;
        start   = 1'b0;
        data_in = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_out", 32'(out), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst = 1'b0;
        check_idle(50);

        run_frame(8'hA5, 1'b0, 0, 0, 0, 1'b0, 8'h00);
        check_idle(5);

        run_frame(8'h00, 1'b0, 0, 0, 0, 1'b1, 8'hFF);
        run_frame(8'hFF, 1'b1, 0, 0, 0, 1'b0, 8'h00);
        check_idle(5);

        run_frame(8'h5A, 1'b0, 40, 0, 0, 1'b0, 8'h00);
        check_idle(40);

        run_frame(8'h55, 1'b0, 0, 70, 1, 1'b0, 8'h00);
        run_frame(8'h55, 1'b0, 0, 0, 0, 1'b0, 8'h00);
        check_idle(3);

        run_frame(8'($urandom), 1'b0, 0, 50, 2, 1'b0, 8'h00);

        run_frame(8'h07, 1'b0, 0, 0, 0, 1'b0, 8'h00);
        check_idle(3);

        for (int k = 0; k < 4; k++) begin
            run_frame(8'($urandom), 1'b0, 0, 0, 0, 1'b0, 8'h00);
            check_idle(int'($urandom_range(1, 6)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
